sha_msg_schedule: RTL and testbench

- Consumer of sigma-stage style outputs: expands a 16-word SHA-2 message block into the full message schedule W[0..N_OUT-1].
- Computes W[t+16] = sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t] on a 16-entry sliding window.
- Rotate and shift amounts are run-time configuration inputs, matching the Versat sigma units.
- Sits between a Versat memory/read unit (input side) and the compression datapath (output side); both sides use valid/ready.

---
 rtl/sha_msg_schedule_pkg.sv | 25 ++
 rtl/sha_msg_schedule_if.sv | 22 ++
 rtl/sha_msg_schedule_sigma.sv | 24 ++
 rtl/sha_msg_schedule.sv | 115 +++++++++++
 tb/tb_sha_msg_schedule.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_msg_schedule_pkg.sv
// Shared definitions for the SHA-2 message schedule expander.
// FSM state encodings, window geometry, recurrence tap positions and SHA-256 default amounts.
package sha_msg_schedule_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } sched_state_t;

  localparam int WIN_DEPTH = 16;

  // Window taps relative to the oldest word w[0] = W[t].
  localparam int TAP_S0  = 1;
  localparam int TAP_ADD = 9;
  localparam int TAP_S1  = 14;

  localparam int SHA256_S0_ROT_A = 7;
  localparam int SHA256_S0_ROT_B = 18;
  localparam int SHA256_S0_SHR   = 3;
  localparam int SHA256_S1_ROT_A = 17;
  localparam int SHA256_S1_ROT_B = 19;
  localparam int SHA256_S1_SHR   = 10;

endpackage

// File: rtl/sha_msg_schedule_if.sv
// Word stream in from the memory read unit and schedule stream out to the compression datapath.
// Both directions use valid/ready; the schedule block is the slave on both.
interface sha_msg_schedule_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sha_msg_schedule_sigma.sv
// Combinational sigma unit: y = ROTR(x,rot_a) ^ ROTR(x,rot_b) ^ SHR(x,shr).
// Zero latency, no handshake; an amount of zero passes x through unchanged.
module sched_sigma #(
  parameter int DATA_W = 32,
  parameter int SH_W   = 5
) (
  input  logic [DATA_W-1:0] x,
  input  logic [SH_W-1:0]   rot_a,
  input  logic [SH_W-1:0]   rot_b,
  input  logic [SH_W-1:0]   shr,
  output logic [DATA_W-1:0] y
);

  // Shifting a doubled copy right leaves the rotation in the low half.
  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] v,
                                             input logic [SH_W-1:0]   n);
    logic [2*DATA_W-1:0] d;
    d = {v, v} >> n;
    return d[DATA_W-1:0];
  endfunction

  assign y = rotr(x, rot_a) ^ rotr(x, rot_b) ^ (x >> shr);

endmodule

// File: rtl/sha_msg_schedule.sv
// Expands a 16-word SHA-2 block into W[0..N_OUT-1] over a 16-entry sliding window.
// First word the cycle after the 16th input fire, then one word per cycle; out_ready low freezes the window.
module sha_msg_schedule
  import sha_msg_schedule_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_OUT  = 64,
  parameter int SH_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  sha_msg_schedule_if.slave bus,
  output logic              done,
  output logic              busy,
  input  logic [31:0]       s0_rot_a,
  input  logic [31:0]       s0_rot_b,
  input  logic [31:0]       s0_shr,
  input  logic [31:0]       s1_rot_a,
  input  logic [31:0]       s1_rot_b,
  input  logic [31:0]       s1_shr
);

  sched_state_t      state_q, state_d;
  logic [5:0]        cnt_q;
  logic [DATA_W-1:0] w_q [WIN_DEPTH];
  logic              done_q, busy_q;
  logic              in_fire, out_fire, load_last, emit_last;
  logic [DATA_W-1:0] s0_y, s1_y, w_next;
  logic              sh_unused;

  // Amounts are used modulo 2^SH_W; the upper bits are deliberately ignored.
  assign sh_unused = ^{s0_rot_a[31:SH_W], s0_rot_b[31:SH_W], s0_shr[31:SH_W],
                       s1_rot_a[31:SH_W], s1_rot_b[31:SH_W], s1_shr[31:SH_W]};

  sched_sigma #(.DATA_W(DATA_W), .SH_W(SH_W)) u_sigma0 (
    .x     (w_q[TAP_S0]),
    .rot_a (s0_rot_a[SH_W-1:0]),
    .rot_b (s0_rot_b[SH_W-1:0]),
    .shr   (s0_shr[SH_W-1:0]),
    .y     (s0_y)
  );

  sched_sigma #(.DATA_W(DATA_W), .SH_W(SH_W)) u_sigma1 (
    .x     (w_q[TAP_S1]),
    .rot_a (s1_rot_a[SH_W-1:0]),
    .rot_b (s1_rot_b[SH_W-1:0]),
    .shr   (s1_shr[SH_W-1:0]),
    .y     (s1_y)
  );

  assign w_next = s1_y + w_q[TAP_ADD] + s0_y + w_q[0];

  assign in_fire   = bus.in_valid & bus.in_ready;
  assign out_fire  = bus.out_valid & bus.out_ready;
  assign load_last = in_fire && (cnt_q == 6'(WIN_DEPTH - 1));
  assign emit_last = out_fire && (cnt_q == 6'(N_OUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run)       state_d = ST_LOAD;
      ST_LOAD: if (load_last) state_d = ST_EMIT;
      ST_EMIT: if (emit_last) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      ST_LOAD: bus.in_ready  = 1'b1;
      ST_EMIT: bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN_DEPTH; i++) w_q[i] <= '0;
      cnt_q <= '0;
    end else if (state_q == ST_IDLE && run) begin
      cnt_q <= '0;
    end else if (in_fire) begin
      w_q[cnt_q[3:0]] <= bus.in_data;
      cnt_q           <= load_last ? 6'd0 : cnt_q + 6'd1;
    end else if (out_fire) begin
      for (int i = 0; i < WIN_DEPTH - 1; i++) w_q[i] <= w_q[i+1];
      w_q[WIN_DEPTH-1] <= w_next;
      cnt_q            <= emit_last ? 6'd0 : cnt_q + 6'd1;
    end
  end

  // busy mirrors the state register, so done (first IDLE cycle) never overlaps it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= emit_last;
      busy_q <= (state_d != ST_IDLE);
    end
  end

  assign done         = done_q;
  assign busy         = busy_q;
  assign bus.out_data = w_q[0];

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Bench for sha_msg_schedule: a 64-word build checked against a direct W[t] recurrence model, plus a 16-word echo build.
module tb_sha_msg_schedule;
  import sha_msg_schedule_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run_a, run_b, done_a, busy_a, done_b, busy_b;
  logic [31:0] s0_rot_a, s0_rot_b, s0_shr, s1_rot_a, s1_rot_b, s1_shr;

  sha_msg_schedule_if #(.DATA_W(32)) bus_a ();
  sha_msg_schedule_if #(.DATA_W(32)) bus_b ();

  sha_msg_schedule #(.DATA_W(32), .N_OUT(64), .SH_W(5)) dut_a (
    .clk(clk), .rst(rst), .run(run_a), .bus(bus_a), .done(done_a), .busy(busy_a),
    .s0_rot_a(s0_rot_a), .s0_rot_b(s0_rot_b), .s0_shr(s0_shr),
    .s1_rot_a(s1_rot_a), .s1_rot_b(s1_rot_b), .s1_shr(s1_shr)
  );

  sha_msg_schedule #(.DATA_W(32), .N_OUT(16), .SH_W(5)) dut_b (
    .clk(clk), .rst(rst), .run(run_b), .bus(bus_b), .done(done_b), .busy(busy_b),
    .s0_rot_a(s0_rot_a), .s0_rot_b(s0_rot_b), .s0_shr(s0_shr),
    .s1_rot_a(s1_rot_a), .s1_rot_b(s1_rot_b), .s1_shr(s1_shr)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Written by the stimulus process only.
  logic [31:0] cur_blk [16];
  logic [31:0] exp_w   [64];
  logic [31:0] blk_b   [16];
  logic [31:0] pin_val [3];
  int pin_n   = 0;
  int blk_id  = 0;
  int end_req = 0;
  int b_end   = 0;
  int run_cyc = 0;
  bit lat_req = 1'b0;

  // Written by the compare process only.
  int seen_blk = 0, seen_end = 0, seen_b_end = 0;
  int out_idx = 0, in_idx = 0, done_cnt = 0, done_cyc = 0;
  int b_idx = 0, b_in_idx = 0, b_done = 0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    int k = n % 32;
    if (k == 0) return x;
    return (x >> k) | (x << (32 - k));
  endfunction

  function automatic logic [31:0] sig(input logic [31:0] x, input int a, input int b, input int s);
    return rotr(x, a) ^ rotr(x, b) ^ (x >> (s % 32));
  endfunction

  // Textbook recurrence over the whole schedule array.
  task automatic build_model();
    for (int t = 0; t < 16; t++) exp_w[t] = cur_blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = sig(exp_w[t-2], int'(s1_rot_a), int'(s1_rot_b), int'(s1_shr)) + exp_w[t-7]
               + sig(exp_w[t-15], int'(s0_rot_a), int'(s0_rot_b), int'(s0_shr)) + exp_w[t-16];
  endtask

  always @(negedge clk) begin
    if (blk_id != seen_blk) begin
      seen_blk = blk_id; out_idx = 0; in_idx = 0; done_cnt = 0; prev_stall = 1'b0;
    end
    if (rst) begin
      chk("rst_a_in_ready",  32'(bus_a.in_ready),  0);
      chk("rst_a_out_valid", 32'(bus_a.out_valid), 0);
      chk("rst_a_out_data",  bus_a.out_data,       0);
      chk("rst_a_done",      32'(done_a),          0);
      chk("rst_a_busy",      32'(busy_a),          0);
      chk("rst_b_out_valid", 32'(bus_b.out_valid), 0);
      chk("rst_b_out_data",  bus_b.out_data,       0);
      prev_stall = 1'b0;
    end else begin
      if (!busy_a) begin
        chk("a_idle_in_ready",  32'(bus_a.in_ready),  0);
        chk("a_idle_out_valid", 32'(bus_a.out_valid), 0);
      end
      if (prev_stall) begin
        chk("a_hold_valid", 32'(bus_a.out_valid), 1);
        chk("a_hold_data",  bus_a.out_data, prev_data);
      end
      if (bus_a.out_valid) begin
        chk("a_in_ready_emit", 32'(bus_a.in_ready), 0);
        if (out_idx < 64) chk($sformatf("a_w[%0d]", out_idx), bus_a.out_data, exp_w[out_idx]);
        else              chk("a_extra_word", 32'(out_idx), 63);
        if (bus_a.out_ready) begin
          if (out_idx >= 16 && out_idx < 16 + pin_n)
            chk($sformatf("a_pin_w%0d", out_idx), bus_a.out_data, pin_val[out_idx-16]);
          out_idx++;
        end
      end
      prev_stall = bus_a.out_valid && !bus_a.out_ready;
      prev_data  = bus_a.out_data;
      if (bus_a.in_valid && bus_a.in_ready) in_idx++;
      if (done_a) begin
        done_cnt++;
        done_cyc = cyc;
        chk("a_done_with_busy", 32'(busy_a), 0);
      end

      if (!busy_b) chk("b_idle_in_ready", 32'(bus_b.in_ready), 0);
      if (bus_b.out_valid) begin
        chk("b_in_ready_emit", 32'(bus_b.in_ready), 0);
        if (b_idx < 16) chk($sformatf("b_echo[%0d]", b_idx), bus_b.out_data, blk_b[b_idx]);
        else            chk("b_extra_word", 32'(b_idx), 15);
        if (bus_b.out_ready) b_idx++;
      end
      if (bus_b.in_valid && bus_b.in_ready) b_in_idx++;
      if (done_b) begin
        b_done++;
        chk("b_done_with_busy", 32'(busy_b), 0);
      end
    end
    if (end_req != seen_end) begin
      seen_end = end_req;
      chk("a_done_once",  32'(done_cnt), 1);
      chk("a_word_count", 32'(out_idx), 64);
      chk("a_in_count",   32'(in_idx), 16);
      if (lat_req) chk("a_run_to_done", 32'(done_cyc - run_cyc), 80);
    end
    if (b_end != seen_b_end) begin
      seen_b_end = b_end;
      chk("b_done_once",  32'(b_done), 1);
      chk("b_word_count", 32'(b_idx), 16);
      chk("b_in_count",   32'(b_in_idx), 16);
    end
  end

  task automatic set_sha_amounts(input int extra);
    s0_rot_a = 32'(SHA256_S0_ROT_A + extra); s0_rot_b = 32'(SHA256_S0_ROT_B + extra);
    s0_shr   = 32'(SHA256_S0_SHR + extra);   s1_rot_a = 32'(SHA256_S1_ROT_A + extra);
    s1_rot_b = 32'(SHA256_S1_ROT_B + extra); s1_shr   = 32'(SHA256_S1_SHR + extra);
  endtask

  task automatic run_block(input bit lat, input int vgap, input int rstall, input bit mid_run);
    build_model();
    @(posedge clk); #1;
    blk_id++;
    run_a = 1'b1; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    run_cyc = cyc + 1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      run_a = mid_run && busy_a && ($urandom_range(0, 3) == 0);
      if (in_idx < 16) begin
        bus_a.in_valid = ($urandom_range(0, 99) >= vgap);
        bus_a.in_data  = cur_blk[in_idx];
      end else begin
        bus_a.in_valid = 1'($urandom_range(0, 1));
        bus_a.in_data  = $urandom;
      end
      bus_a.out_ready = ($urandom_range(0, 99) >= rstall);
      if (done_cnt != 0) break;
    end
    run_a = 1'b0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    lat_req = lat;
    end_req++;
    @(negedge clk);
  endtask

  task automatic rst_mid_block();
    @(posedge clk); #1;
    blk_id++;
    for (int t = 0; t < 16; t++) cur_blk[t] = 32'hDEAD_0000 | 32'(t);
    run_a = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      run_a = 1'b0;
      if (in_idx >= 7) break;
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = cur_blk[in_idx];
    end
    rst = 1'b1;
    bus_a.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_b_block();
    for (int t = 0; t < 16; t++) blk_b[t] = 32'hB0B0_0000 | 32'(t * 17);
    @(posedge clk); #1;
    run_b = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      run_b = 1'b0;
      bus_b.in_valid  = 1'b1;
      bus_b.in_data   = (b_in_idx < 16) ? blk_b[b_in_idx] : 32'hFFFF_FFFF;
      bus_b.out_ready = 1'b1;
      if (b_done != 0) break;
    end
    repeat (4) @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
    b_end++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; run_a = 1'b0; run_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    set_sha_amounts(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // "abc" padded block, SHA-256 amounts, no backpressure.
    for (int t = 0; t < 16; t++) cur_blk[t] = '0;
    cur_blk[0]  = 32'h6162_6380;
    cur_blk[15] = 32'h0000_0018;
    pin_val[0] = 32'h6162_6380; pin_val[1] = 32'h000F_0000; pin_val[2] = 32'h7DA8_6405;
    pin_n = 3;
    run_block(1'b1, 0, 0, 1'b0);

    // Same block, amounts offset by 32, input gaps and ~50% out_ready.
    set_sha_amounts(32);
    run_block(1'b0, 30, 50, 1'b0);

    // All amounts zero, all words one.
    s0_rot_a = 0; s0_rot_b = 0; s0_shr = 0; s1_rot_a = 0; s1_rot_b = 0; s1_shr = 0;
    for (int t = 0; t < 16; t++) cur_blk[t] = 32'h1;
    pin_val[0] = 32'h0000_0004;
    pin_n = 1;
    run_block(1'b1, 0, 0, 1'b0);

    // Reset after 7 words, then a fresh block.
    set_sha_amounts(0);
    pin_n = 0;
    rst_mid_block();
    for (int t = 0; t < 16; t++) cur_blk[t] = 32'(t + 1) * 32'h9E37_79B9;
    run_block(1'b1, 0, 0, 1'b0);

    // Stray run pulses during LOAD and EMIT.
    for (int t = 0; t < 16; t++) cur_blk[t] = 32'hA5A5_0F0F ^ (32'(t) << 9);
    run_block(1'b0, 20, 30, 1'b1);

    run_b_block();

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
